// File: rtl/quick_spi_master.sv
// -----------------------------------------------------------------------------
// quick_spi_master
//   Parametrised full-duplex SPI master. One accepted request shifts
//   DATA_WIDTH bits out on mosi while capturing DATA_WIDTH bits from miso.
//   Each transfer latches its own CPOL/CPHA mode, bit order and target slave.
//   A new request for the same slave at the completion edge chains a burst
//   word with chip select held low.
//
// Ports
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   start_transaction   transfer request, sampled on clk edges
//   slave               target chip-select index
//   cpol / cpha         SPI mode for the requested word
//   lsb_first           1 = shift least significant bit first
//   outgoing_data       word to transmit
//   incoming_data       last received word, held until the next completion
//   end_of_transaction  one-cycle pulse per completed word
//   busy                high from accept until the word completes
//   mosi / miso         serial data out / in
//   sclk                SPI clock
//   ss_n                active-low chip selects
// -----------------------------------------------------------------------------
module quick_spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 2,
  parameter int SEL_WIDTH  = 1,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_transaction,
  input  logic [SEL_WIDTH-1:0]  slave,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] outgoing_data,
  output logic [DATA_WIDTH-1:0] incoming_data,
  output logic                  end_of_transaction,
  output logic                  busy,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  sclk,
  output logic [NUM_SLAVES-1:0] ss_n
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Edge count value just before the final (2*DATA_WIDTH-th) SCLK edge.
  localparam logic [EDGE_W-1:0] EDGE_PEN = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic [DATA_WIDTH-1:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   incoming_q, incoming_d;
  logic                    mosi_q, mosi_d;
  logic                    sclk_q, sclk_d;
  logic [NUM_SLAVES-1:0]   ss_n_q, ss_n_d;
  logic                    eot_q, eot_d;
  logic [SEL_WIDTH-1:0]    slave_q, slave_d;
  logic                    cpol_q, cpol_d;
  logic                    cpha_q, cpha_d;
  logic                    lsb_q, lsb_d;

  logic tick;
  logic slave_ok;
  logic done;
  logic burst;
  logic load;
  logic leading;

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                      input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  // The first received bit ends up where the peer transmitted it from:
  // the MSB end when shifting MSB first, the LSB end otherwise.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                     input logic b, input logic lsb);
    return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
  endfunction

  assign tick     = (div_cnt_q == DIV_LAST);
  assign slave_ok = (32'(slave) < 32'(NUM_SLAVES));
  assign done     = (state_q == HOLD) && tick;
  assign burst    = done && start_transaction && (slave == slave_q);
  assign load     = ((state_q == IDLE) && start_transaction && slave_ok) || burst;
  // Edge k = edge_cnt_q + 1; odd k (even count) is a leading edge.
  assign leading  = ~edge_cnt_q[0];

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    incoming_d = incoming_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    eot_d      = 1'b0;
    slave_d    = slave_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;

    if (state_q != IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        ss_n_d = '1;
      end
      SETUP: begin
        if (tick) state_d = TRANSFER;
      end
      TRANSFER: begin
        if (tick) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (leading ^ cpha_q) begin
            rx_d = shift_in(rx_q, miso, lsb_q);
          end else if (cpha_q || (edge_cnt_q != EDGE_PEN)) begin
            // CPHA=0 already presented bit 0 at accept, so its last
            // trailing edge has nothing left to shift.
            mosi_d = head_bit(tx_q, lsb_q);
            tx_d   = shift_out(tx_q, lsb_q);
          end
          if (edge_cnt_q == EDGE_PEN) state_d = HOLD;
        end
      end
      HOLD: begin
        if (done) begin
          incoming_d = rx_q;
          eot_d      = 1'b1;
          state_d    = IDLE;
          mosi_d     = 1'b0;
          ss_n_d     = '1;
          sclk_d     = cpol_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept from IDLE or chain a burst word; overrides the completion
    // defaults above so ss_n stays low for the same slave.
    if (load) begin
      state_d    = SETUP;
      div_cnt_d  = '0;
      edge_cnt_d = '0;
      rx_d       = '0;
      slave_d    = slave;
      cpol_d     = cpol;
      cpha_d     = cpha;
      lsb_d      = lsb_first;
      sclk_d     = cpol;
      for (int i = 0; i < NUM_SLAVES; i++) begin
        ss_n_d[i] = (slave != SEL_WIDTH'(i));
      end
      if (cpha) begin
        mosi_d = 1'b0;
        tx_d   = outgoing_data;
      end else begin
        mosi_d = head_bit(outgoing_data, lsb_first);
        tx_d   = shift_out(outgoing_data, lsb_first);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      incoming_q <= '0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= '1;
      eot_q      <= 1'b0;
      slave_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      incoming_q <= incoming_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      eot_q      <= eot_d;
      slave_q    <= slave_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
    end
  end

  assign incoming_data      = incoming_q;
  assign end_of_transaction = eot_q;
  assign busy               = (state_q != IDLE);
  assign mosi               = mosi_q;
  assign sclk               = sclk_q;
  assign ss_n               = ss_n_q;

endmodule

// File: tb/tb_quick_spi_master.sv
// -----------------------------------------------------------------------------
// tb_quick_spi_master
//   Two instances: A (8-bit, 2 slaves, 2-bit select, CLK_DIV=2) with a
//   behavioural SPI slave or loopback on miso, and B (16-bit, CLK_DIV=1)
//   with mosi looped back to miso. Drivers push expected words and end
//   cycles into per-instance queues; monitors pop on every end pulse.
// -----------------------------------------------------------------------------
module tb_quick_spi_master;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Instance A signals
  logic       start_a, cpol_a, cpha_a, lsb_a;
  logic [1:0] slave_a;
  logic [7:0] out_a, in_a;
  logic       eot_a, busy_a, mosi_a, miso_a, sclk_a;
  logic [1:0] ss_n_a;

  // Instance B signals
  logic        start_b, cpol_b, cpha_b, lsb_b;
  logic        slave_b;
  logic [15:0] out_b, in_b;
  logic        eot_b, busy_b, mosi_b, sclk_b;
  logic [1:0]  ss_n_b;

  quick_spi_master #(.DATA_WIDTH(8), .NUM_SLAVES(2), .SEL_WIDTH(2), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start_transaction(start_a), .slave(slave_a),
    .cpol(cpol_a), .cpha(cpha_a), .lsb_first(lsb_a), .outgoing_data(out_a),
    .incoming_data(in_a), .end_of_transaction(eot_a), .busy(busy_a),
    .mosi(mosi_a), .miso(miso_a), .sclk(sclk_a), .ss_n(ss_n_a));

  quick_spi_master #(.DATA_WIDTH(16), .NUM_SLAVES(2), .SEL_WIDTH(1), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start_transaction(start_b), .slave(slave_b),
    .cpol(cpol_b), .cpha(cpha_b), .lsb_first(lsb_b), .outgoing_data(out_b),
    .incoming_data(in_b), .end_of_transaction(eot_b), .busy(busy_b),
    .mosi(mosi_b), .miso(mosi_b), .sclk(sclk_b), .ss_n(ss_n_b));

  // Behavioural SPI slave on instance A
  bit         m_cpol = 0, m_cpha = 0, m_lsb = 0, loop_a = 0;
  logic [7:0] slv_tx = 8'h00, slv_rx = 8'h00;
  int         slv_out = 0, slv_in = 0, slv_edges = 0;
  logic       slv_miso = 1'b0;
  logic [1:0] ss_prev = 2'b11;
  logic       sclk_prev = 1'b0;

  assign miso_a = loop_a ? mosi_a : slv_miso;

  function automatic logic slv_bit(input logic [7:0] w, input int i, input bit lsb);
    if (i > 7) return 1'b0;
    return lsb ? w[i] : w[7-i];
  endfunction

  always @(ss_n_a or sclk_a) begin
    if (ss_n_a != 2'b11 && ss_prev == 2'b11) begin
      slv_out   = 0;
      slv_in    = 0;
      slv_edges = 0;
      slv_rx    = 8'h00;
      slv_miso  = m_cpha ? 1'b0 : slv_bit(slv_tx, 0, m_lsb);
    end else if (ss_n_a != 2'b11 && sclk_a != sclk_prev) begin
      slv_edges++;
      if ((sclk_a != m_cpol) ^ m_cpha) begin
        if (slv_in < 8) slv_rx[m_lsb ? slv_in : 7 - slv_in] = mosi_a;
        slv_in++;
      end else if (m_cpha) begin
        slv_miso = slv_bit(slv_tx, slv_out, m_lsb);
        slv_out++;
      end else begin
        slv_out++;
        slv_miso = slv_bit(slv_tx, slv_out, m_lsb);
      end
    end
    ss_prev   = ss_n_a;
    sclk_prev = sclk_a;
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
    logic [7:0]  tx;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && eot_a === 1'b1) begin
      if (sb_a.size() == 0) begin
        check("a_spurious_end", 32'(eot_a), 32'd0);
      end else begin
        e = sb_a.pop_front();
        check("a_incoming", 32'(in_a), e.data);
        check("a_end_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk) begin
          check("a_slave_rx", 32'(slv_rx), 32'(e.tx));
          check("a_sclk_edges", 32'(slv_edges), 32'd16);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && eot_b === 1'b1) begin
      if (sb_b.size() == 0) begin
        check("b_spurious_end", 32'(eot_b), 32'd0);
      end else begin
        e = sb_b.pop_front();
        check("b_incoming", 32'(in_b), e.data);
        check("b_end_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic set_mode_a(input bit pol, input bit pha, input bit lsb, input bit lp);
    @(posedge clk); #1;
    cpol_a = pol; cpha_a = pha; lsb_a = lsb;
    m_cpol = pol; m_cpha = pha; m_lsb = lsb; loop_a = lp;
    repeat (2) @(posedge clk); #1;
    check("a_idle_sclk", 32'(sclk_a), 32'(pol));
  endtask

  task automatic xfer_a(input logic [7:0] w, input logic [1:0] sl, input bit pol,
                        input bit pha, input bit lsb, input bit lp, input logic [7:0] sw);
    int t0;
    exp_t e;
    logic [1:0] exp_ss;
    slv_tx = sw;
    set_mode_a(pol, pha, lsb, lp);
    start_a = 1'b1; slave_a = sl; out_a = w;
    t0 = cyc + 1;
    e.data = 32'(lp ? w : sw); e.cyc = t0 + 36; e.chk = 1'b1; e.tx = w;
    sb_a.push_back(e);
    @(posedge clk); #1;
    start_a = 1'b0; out_a = 8'($urandom);
    repeat (5) @(posedge clk); #1;
    exp_ss = ~(2'b01 << sl);
    check("a_ss_n_active", 32'(ss_n_a), 32'(exp_ss));
    check("a_busy_active", 32'(busy_a), 32'd1);
    repeat (31) @(posedge clk);
  endtask

  task automatic burst_a();
    int t0;
    exp_t e;
    bit ssbad = 1'b0;
    set_mode_a(1'b0, 1'b0, 1'b0, 1'b1);
    start_a = 1'b1; slave_a = 2'd1; out_a = 8'h12;
    t0 = cyc + 1;
    e.chk = 1'b0; e.tx = 8'h00;
    e.data = 32'h12; e.cyc = t0 + 36; sb_a.push_back(e);
    e.data = 32'h34; e.cyc = t0 + 72; sb_a.push_back(e);
    @(posedge clk); #1;
    out_a = 8'h34;
    for (int c = 1; c <= 72; c++) begin
      @(posedge clk); #1;
      if (c == 36) start_a = 1'b0;
      if (c < 72 && ss_n_a !== 2'b01) ssbad = 1'b1;
    end
    check("burst_ss_n_held", 32'(ssbad), 32'd0);
    check("burst_ss_n_release", 32'(ss_n_a), 32'd3);
  endtask

  task automatic bad_slave_a(input logic [1:0] sl);
    bit seen = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b1; slave_a = sl; out_a = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 3) start_a = 1'b0;
      if (busy_a !== 1'b0 || ss_n_a !== 2'b11) seen = 1'b1;
    end
    start_a = 1'b0;
    check("bad_slave_ignored", 32'(seen), 32'd0);
  endtask

  task automatic abort_a();
    int t0;
    exp_t e;
    set_mode_a(1'b1, 1'b0, 1'b0, 1'b1);
    start_a = 1'b1; slave_a = 2'd0; out_a = 8'hA5;
    t0 = cyc + 1;
    e.data = 32'hA5; e.cyc = t0 + 36; e.chk = 1'b0; e.tx = 8'h00;
    sb_a.push_back(e);
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    sb_a.delete();
    #1;
    check("abort_ss_n", 32'(ss_n_a), 32'd3);
    check("abort_sclk", 32'(sclk_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_mosi", 32'(mosi_a), 32'd0);
    check("abort_incoming", 32'(in_a), 32'd0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic xfer_b(input logic [15:0] w, input bit pol, input bit pha, input bit lsb);
    int t0;
    exp_t e;
    @(posedge clk); #1;
    cpol_b = pol; cpha_b = pha; lsb_b = lsb;
    repeat (2) @(posedge clk); #1;
    check("b_idle_sclk", 32'(sclk_b), 32'(pol));
    start_b = 1'b1; slave_b = 1'b0; out_b = w;
    t0 = cyc + 1;
    e.data = 32'(w); e.cyc = t0 + 34; e.chk = 1'b0; e.tx = 8'h00;
    sb_b.push_back(e);
    @(posedge clk); #1;
    start_b = 1'b0; out_b = 16'($urandom);
    repeat (33) @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b1;
    start_a = 1'b0; slave_a = 2'd0; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0; out_a = 8'h00;
    start_b = 1'b0; slave_b = 1'b0; cpol_b = 1'b0; cpha_b = 1'b0; lsb_b = 1'b0; out_b = 16'h0000;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_ss_n", 32'(ss_n_a), 32'd3);
    check("reset_sclk", 32'(sclk_a), 32'd0);
    check("reset_mosi", 32'(mosi_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_eot", 32'(eot_a), 32'd0);
    check("reset_incoming", 32'(in_a), 32'd0);
    check("reset_b_ss_n", 32'(ss_n_b), 32'd3);
    reset_n = 1'b1;

    xfer_a(8'h6A, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h95);
    xfer_a(8'h1A, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    burst_a();
    bad_slave_a(2'd2);
    bad_slave_a(2'd3);
    abort_a();
    xfer_a(8'hC3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5C);
    for (int i = 0; i < 8; i++) begin
      xfer_a(8'($urandom), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom));
    end

    xfer_b(16'hBEEF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer_b(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk); #1;
    check("a_pending_ends", 32'(sb_a.size()), 32'd0);
    check("b_pending_ends", 32'(sb_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
